// File: rtl/pwm5_compare_pkg.sv
// Shared types and widths for the PWM compare block and its config shadow slot.
package pwm5_compare_pkg;

   localparam int CNT_W  = 5;
   localparam int DUTY_W = CNT_W + 1;
   localparam logic [DUTY_W-1:0] DUTY_FULL = DUTY_W'(1 << CNT_W);

   typedef enum logic [1:0] {
      IDLE,
      SYNC,
      RUN
   } state_t;

endpackage

// File: rtl/pwm5_compare_if.sv
// Valid/ready configuration channel carrying a duty threshold and polarity.
interface pwm5_compare_if
   import pwm5_compare_pkg::*;
#(
   parameter int WIDTH = CNT_W
);

   logic           cfg_valid;
   logic           cfg_ready;
   logic [WIDTH:0] cfg_duty;
   logic           cfg_inv;

   modport master (output cfg_valid, output cfg_duty, output cfg_inv, input cfg_ready);
   modport slave  (input cfg_valid, input cfg_duty, input cfg_inv, output cfg_ready);

endinterface

// File: rtl/pwm5_shadow_reg.sv
// One-deep config slot; its contents are promoted to the active settings only on a counter wrap.
module pwm5_shadow_reg
   import pwm5_compare_pkg::*;
#(
   parameter int WIDTH = CNT_W
) (
   input  logic           clk,
   input  logic           rstn,
   input  logic           wrap,
   pwm5_compare_if.slave  cfg,
   output logic [WIDTH:0] eff_duty,
   output logic           eff_inv
);

   logic           pending_v;
   logic [WIDTH:0] pending_duty;
   logic           pending_inv;
   logic [WIDTH:0] active_duty;
   logic           active_inv;

   logic xfer;
   logic promote;

   assign cfg.cfg_ready = !pending_v;
   assign xfer          = cfg.cfg_valid && !pending_v;
   assign promote       = wrap && pending_v;

   // The compare on a wrap cycle already sees the freshly promoted settings.
   assign eff_duty = promote ? pending_duty : active_duty;
   assign eff_inv  = promote ? pending_inv  : active_inv;

   // xfer needs an empty slot and promote a full one, so they never collide.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         // NOTE: data registers are reset too, so no X ever reaches pwm_out through eff_duty.
         pending_v    <= 1'b0;
         pending_duty <= '0;
         pending_inv  <= 1'b0;
         active_duty  <= '0;
         active_inv   <= 1'b0;
      end else begin
         if (promote) begin
            active_duty <= pending_duty;
            active_inv  <= pending_inv;
            pending_v   <= 1'b0;
         end
         if (xfer) begin
            pending_duty <= cfg.cfg_duty;
            pending_inv  <= cfg.cfg_inv;
            pending_v    <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/pwm5_compare.sv
// Registered PWM generator: compares the live count against the active duty, starting only on a wrap.
module pwm5_compare
   import pwm5_compare_pkg::*;
#(
   parameter int WIDTH = CNT_W
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             en,
   input  logic [WIDTH-1:0] cnt_in,
   pwm5_compare_if.slave    cfg,
   output logic             pwm_out,
   output logic             period_tick,
   output logic             busy
);

   state_t         state;
   logic [WIDTH-1:0] cnt_prev;
   logic           wrap;
   logic           cmp;
   logic [WIDTH:0] eff_duty;
   logic           eff_inv;

   // A counter parked at zero must not retrigger, hence the previous-value qualifier.
   assign wrap = (cnt_in == '0) && (cnt_prev != '0);
   assign cmp  = ({1'b0, cnt_in} < eff_duty) ^ eff_inv;

   pwm5_shadow_reg #(.WIDTH(WIDTH)) u_shadow (
      .clk      (clk),
      .rstn     (rstn),
      .wrap     (wrap),
      .cfg      (cfg),
      .eff_duty (eff_duty),
      .eff_inv  (eff_inv)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_prev <= '0;
      end else begin
         // NOTE: non-blocking assignments make every register sample pre-edge values, independent of block order.
         cnt_prev <= cnt_in;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= IDLE;
         pwm_out     <= 1'b0;
         period_tick <= 1'b0;
         busy        <= 1'b0;
      end else if (!en) begin
         state       <= IDLE;
         pwm_out     <= eff_inv;
         period_tick <= 1'b0;
         busy        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state       <= SYNC;
               pwm_out     <= eff_inv;
               period_tick <= 1'b0;
               busy        <= 1'b1;
            end
            SYNC: begin
               busy <= 1'b1;
               if (wrap) begin
                  state       <= RUN;
                  pwm_out     <= cmp;
                  period_tick <= 1'b1;
               end else begin
                  pwm_out     <= eff_inv;
                  period_tick <= 1'b0;
               end
            end
            RUN: begin
               pwm_out     <= cmp;
               period_tick <= wrap;
               busy        <= 1'b1;
            end
            default: begin
               state       <= IDLE;
               pwm_out     <= eff_inv;
               period_tick <= 1'b0;
               busy        <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pwm5_compare.sv
// Directed bench for pwm5_compare: a sweeping 0..31 count, config handshakes, boundaries, enable and reset.
module tb_pwm5_compare;
   import pwm5_compare_pkg::*;

   logic             clk = 1'b0;
   logic             rstn;
   logic             en;
   logic [CNT_W-1:0] cnt_in;
   logic             pwm_out;
   logic             period_tick;
   logic             busy;

   pwm5_compare_if #(.WIDTH(CNT_W)) cfg_if ();

   pwm5_compare #(.WIDTH(CNT_W)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .en          (en),
      .cnt_in      (cnt_in),
      .cfg         (cfg_if),
      .pwm_out     (pwm_out),
      .period_tick (period_tick),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int tests  = 0;
   int errors = 0;
   int cnt    = 0;
   int last   = 0;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Apply the next count, clock once, and land 1 time unit after the edge.
   task automatic step();
      cnt_in = CNT_W'(cnt);
      @(posedge clk);
      #1;
      last = cnt;
      cnt  = (cnt + 1) % 32;
   endtask

   function automatic logic exp_pwm(input int c, input int d, input bit inv);
      logic hi;
      hi = (c < d) ? 1'b1 : 1'b0;
      return hi ^ inv;
   endfunction

   // One full RUN period (count 0..31) expecting duty d / polarity inv; optionally offers a new config.
   task automatic run_period(input string name, input int d, input bit inv,
                             input int offer_at, input int nd, input bit ninv);
      for (int i = 0; i < 32; i++) begin
         if (i == offer_at) begin
            cfg_if.cfg_valid = 1'b1;
            cfg_if.cfg_duty  = DUTY_W'(nd);
            cfg_if.cfg_inv   = ninv;
         end
         step();
         cfg_if.cfg_valid = 1'b0;
         tests++;
         if (pwm_out !== exp_pwm(last, d, inv) || period_tick !== (last == 0) || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s cnt=%0d: pwm=%b tick=%b busy=%b, want pwm=%b tick=%b busy=1",
                     name, last, pwm_out, period_tick, busy, exp_pwm(last, d, inv), (last == 0));
         end
         if (i == offer_at) begin
            tests++;
            if (cfg_if.cfg_ready !== 1'b0) begin
               errors++;
               $display("FAIL %s ready_after_offer cnt=%0d: got %b want 0", name, last, cfg_if.cfg_ready);
            end
         end else if (i == 0) begin
            tests++;
            if (cfg_if.cfg_ready !== 1'b1) begin
               errors++;
               $display("FAIL %s ready_after_wrap: got %b want 1", name, cfg_if.cfg_ready);
            end
         end
      end
   endtask

   task automatic test_reset();
      rstn             = 1'b1;
      en               = 1'b0;
      cnt_in           = '0;
      cfg_if.cfg_valid = 1'b0;
      cfg_if.cfg_duty  = '0;
      cfg_if.cfg_inv   = 1'b0;
      #2 rstn = 1'b0;
      #3;
      tests++;
      if ({pwm_out, period_tick, busy, cfg_if.cfg_ready} !== 4'b0001) begin
         errors++;
         $display("FAIL reset_state: pwm/tick/busy/ready=%b want 0001",
                  {pwm_out, period_tick, busy, cfg_if.cfg_ready});
      end
      @(posedge clk);
      #1 rstn = 1'b1;
   endtask

   task automatic test_first_sync();
      en               = 1'b1;
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_duty  = 6'd8;
      cfg_if.cfg_inv   = 1'b0;
      cnt = 0;
      step();
      cfg_if.cfg_valid = 1'b0;
      tests++;
      if ({pwm_out, busy, cfg_if.cfg_ready} !== 3'b010) begin
         errors++;
         $display("FAIL sync_entry: pwm/busy/ready=%b want 010", {pwm_out, busy, cfg_if.cfg_ready});
      end
      for (int i = 1; i < 32; i++) begin
         step();
         tests++;
         if (pwm_out !== 1'b0 || period_tick !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL sync_wait cnt=%0d: pwm=%b tick=%b busy=%b want 0 0 1",
                     last, pwm_out, period_tick, busy);
         end
      end
      run_period("first_run", 8, 1'b0, -1, 0, 1'b0);
   endtask

   task automatic test_duty_change();
      run_period("chg_old", 8, 1'b0, 10, 20, 1'b0);
      run_period("chg_new", 20, 1'b0, 1, 0, 1'b0);
   endtask

   task automatic test_boundaries();
      run_period("duty0", 0, 1'b0, 1, int'(DUTY_FULL), 1'b0);
      run_period("duty32", 32, 1'b0, 1, 31, 1'b0);
      run_period("duty31", 31, 1'b0, 1, 0, 1'b1);
      run_period("inv_duty0", 0, 1'b1, -1, 0, 1'b0);
   endtask

   task automatic test_wrap_coincident();
      run_period("wrap_old", 0, 1'b1, 0, 4, 1'b0);
      run_period("wrap_new", 4, 1'b0, -1, 0, 1'b0);
   endtask

   task automatic test_pending_full();
      for (int i = 0; i < 32; i++) begin
         if (i == 3) begin
            cfg_if.cfg_valid = 1'b1;
            cfg_if.cfg_duty  = 6'd12;
            cfg_if.cfg_inv   = 1'b0;
         end else if (i >= 6) begin
            cfg_if.cfg_valid = 1'b1;
            cfg_if.cfg_duty  = 6'd20;
            cfg_if.cfg_inv   = 1'b0;
         end
         step();
         if (i == 3) cfg_if.cfg_valid = 1'b0;
         tests++;
         if (pwm_out !== exp_pwm(last, 4, 1'b0) || period_tick !== (last == 0)) begin
            errors++;
            $display("FAIL full_old cnt=%0d: pwm=%b tick=%b want pwm=%b tick=%b",
                     last, pwm_out, period_tick, exp_pwm(last, 4, 1'b0), (last == 0));
         end
         if (i >= 3) begin
            tests++;
            if (cfg_if.cfg_ready !== 1'b0) begin
               errors++;
               $display("FAIL full_ready cnt=%0d: got %b want 0", last, cfg_if.cfg_ready);
            end
         end
      end
      for (int i = 0; i < 32; i++) begin
         step();
         if (i == 1) cfg_if.cfg_valid = 1'b0;
         tests++;
         if (pwm_out !== exp_pwm(last, 12, 1'b0) || period_tick !== (last == 0)) begin
            errors++;
            $display("FAIL full_mid cnt=%0d: pwm=%b tick=%b want pwm=%b tick=%b",
                     last, pwm_out, period_tick, exp_pwm(last, 12, 1'b0), (last == 0));
         end
         if (i < 2) begin
            tests++;
            if (cfg_if.cfg_ready !== (i == 0)) begin
               errors++;
               $display("FAIL full_reaccept cnt=%0d: ready=%b want %b", last, cfg_if.cfg_ready, (i == 0));
            end
         end
      end
      run_period("full_new", 20, 1'b0, 5, 20, 1'b1);
   endtask

   task automatic test_enable_gap();
      for (int i = 0; i < 32; i++) begin
         en = !(i >= 15 && i < 20);
         step();
         tests++;
         if (i < 15) begin
            if (pwm_out !== exp_pwm(last, 20, 1'b1) || period_tick !== (last == 0) || busy !== 1'b1) begin
               errors++;
               $display("FAIL en_run cnt=%0d: pwm=%b tick=%b busy=%b", last, pwm_out, period_tick, busy);
            end
         end else if (pwm_out !== 1'b1 || period_tick !== 1'b0 || busy !== (i >= 20)) begin
            errors++;
            $display("FAIL en_gap cnt=%0d: pwm=%b tick=%b busy=%b want 1 0 %b",
                     last, pwm_out, period_tick, busy, (i >= 20));
         end
      end
      en = 1'b1;
      run_period("en_resume", 20, 1'b1, -1, 0, 1'b0);
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 26; i++) begin
         if (i == 2) begin
            cfg_if.cfg_valid = 1'b1;
            cfg_if.cfg_duty  = 6'd5;
            cfg_if.cfg_inv   = 1'b0;
         end
         step();
         cfg_if.cfg_valid = 1'b0;
      end
      tests++;
      if ({pwm_out, busy, cfg_if.cfg_ready} !== 3'b110) begin
         errors++;
         $display("FAIL pre_reset cnt=%0d: pwm/busy/ready=%b want 110", last, {pwm_out, busy, cfg_if.cfg_ready});
      end
      #2 rstn = 1'b0;
      #1;
      tests++;
      if ({pwm_out, period_tick, busy, cfg_if.cfg_ready} !== 4'b0001) begin
         errors++;
         $display("FAIL async_reset: pwm/tick/busy/ready=%b want 0001",
                  {pwm_out, period_tick, busy, cfg_if.cfg_ready});
      end
      @(posedge clk);
      #1 rstn = 1'b1;
   endtask

   initial begin
      test_reset();
      test_first_sync();
      test_duty_change();
      test_boundaries();
      test_wrap_coincident();
      test_pending_full();
      test_enable_gap();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
